// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared constants for the centisecond timer scheduler
// Purpose: register map, scan FSM encodings and channel count for timer_sched.
// Ports: none (package).
package timer_sched_pkg;

  localparam int NUM_CH = 4;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h1;
  localparam logic [3:0] ADDR_IRQ_EN  = 4'h2;
  localparam logic [3:0] ADDR_CH_SEL  = 4'h3;
  localparam logic [3:0] ADDR_RELOAD_L = 4'h4;
  localparam logic [3:0] ADDR_RELOAD_H = 4'h5;
  localparam logic [3:0] ADDR_COUNT_L = 4'h6;
  localparam logic [3:0] ADDR_COUNT_H = 4'h7;
  localparam logic [3:0] ADDR_MODE    = 4'h8;

  // Bit 2 marks a scan state; bits [1:0] are then the channel being serviced.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_S0   = 3'b100,
    ST_S1   = 3'b101,
    ST_S2   = 3'b110,
    ST_S3   = 3'b111
  } sched_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running centisecond prescaler
// Purpose: counts 0..CS_DIV-1 and pulses tick_o for one cycle at the wrap.
// Ports: clk_i (clock), rst_i (async active-high reset), tick_o (1-cycle tick).
module timer_prescaler #(
  parameter int CS_DIV = 251_750
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = $clog2(CS_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CS_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - four-channel centisecond timer scheduler (top)
// Purpose: shared prescaler, scan FSM time-multiplexing one decrementer over
//   four channel counters, status flags and maskable IRQ on the 6502 I/O bus.
// Ports: clk_i, rst_i (async active-high), R_W_n (1=read), reg_addr_i[3:0],
//   data_i[7:0], timer_cs (chip select), data_o[7:0] (registered read data),
//   irq_o (registered |(status & irq_en)).
// Option: TIMER_SCHED_PERIODIC_EN adds MODE register (0x8) and CTRL stop command.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int CLK_FRE = 25_175_000,
  parameter int CS_DIV  = CLK_FRE / 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       R_W_n,
  input  logic [3:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       timer_cs,
  output logic [7:0] data_o,
  output logic       irq_o
);

  logic tick;

  timer_prescaler #(.CS_DIV(CS_DIV)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  sched_state_e state_q;
  logic         tick_pend_q;

  logic [15:0]       count_q  [NUM_CH];
  logic [15:0]       count_d  [NUM_CH];
  logic [15:0]       reload_q [NUM_CH];
  logic [15:0]       reload_d [NUM_CH];
  logic [NUM_CH-1:0] status_q, status_d, running_q, running_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] set_v, w1c_v;
  logic [1:0]        ch_sel_q, ch_sel_d;
  logic [7:0]        shadow_q, shadow_d, data_d;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [NUM_CH-1:0] mode_q, mode_d;
`endif

  logic       wr_en, rd_en, svc_en;
  logic [1:0] svc_ch;

  assign wr_en  = timer_cs & ~R_W_n;
  assign rd_en  = timer_cs & R_W_n;
  assign svc_en = state_q[2];
  assign svc_ch = state_q[1:0];

  // Scan FSM: ticks seen mid-scan are remembered and restart the scan at S3.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tick_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (tick) state_q <= ST_S0;
        ST_S0, ST_S1, ST_S2: begin
          state_q     <= sched_state_e'(state_q + 3'd1);
          tick_pend_q <= tick_pend_q | tick;
        end
        ST_S3: begin
          state_q     <= (tick_pend_q | tick) ? ST_S0 : ST_IDLE;
          tick_pend_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    running_d = running_q;
    irq_en_d  = irq_en_q;
    ch_sel_d  = ch_sel_q;
    shadow_d  = shadow_q;
    set_v     = '0;
    w1c_v     = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
    mode_d    = mode_q;
`endif

    // Shared decrementer for the channel in its scan slot.
    if (svc_en && running_q[svc_ch]) begin
      if (count_q[svc_ch] > 16'd1) begin
        count_d[svc_ch] = count_q[svc_ch] - 16'd1;
      end else begin
        set_v[svc_ch] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
        if (mode_q[svc_ch] && (reload_q[svc_ch] != 16'd0)) begin
          count_d[svc_ch] = reload_q[svc_ch];
        end else begin
          count_d[svc_ch]   = 16'd0;
          running_d[svc_ch] = 1'b0;
        end
`else
        count_d[svc_ch]   = 16'd0;
        running_d[svc_ch] = 1'b0;
`endif
      end
    end

    // Register writes; CTRL starts come after the service so a start wins.
    if (wr_en) begin
      case (reg_addr_i)
        ADDR_CTRL: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (data_i[n]) begin
              count_d[n] = reload_q[n];
              if (reload_q[n] != 16'd0) begin
                running_d[n] = 1'b1;
              end else begin
                running_d[n] = 1'b0;
                set_v[n]     = 1'b1;
              end
            end
`ifdef TIMER_SCHED_PERIODIC_EN
            else if (data_i[7]) begin
              running_d[n] = 1'b0;
            end
`endif
          end
        end
        ADDR_STATUS:   w1c_v    = data_i[NUM_CH-1:0];
        ADDR_IRQ_EN:   irq_en_d = data_i[NUM_CH-1:0];
        ADDR_CH_SEL:   ch_sel_d = data_i[1:0];
        ADDR_RELOAD_L: reload_d[ch_sel_q][7:0]  = data_i;
        ADDR_RELOAD_H: reload_d[ch_sel_q][15:8] = data_i;
`ifdef TIMER_SCHED_PERIODIC_EN
        ADDR_MODE:     mode_d   = data_i[NUM_CH-1:0];
`endif
        default: ;
      endcase
    end

    // Latching the MSB on the LSB read keeps a two-byte read coherent.
    if (rd_en && (reg_addr_i == ADDR_COUNT_L)) shadow_d = count_q[ch_sel_q][15:8];

    status_d = (status_q & ~w1c_v) | set_v;
  end

  always_comb begin
    data_d = 8'h00;
    case (reg_addr_i)
      ADDR_CTRL:     data_d = {4'h0, running_q};
      ADDR_STATUS:   data_d = {4'h0, status_q};
      ADDR_IRQ_EN:   data_d = {4'h0, irq_en_q};
      ADDR_CH_SEL:   data_d = {6'h00, ch_sel_q};
      ADDR_RELOAD_L: data_d = reload_q[ch_sel_q][7:0];
      ADDR_RELOAD_H: data_d = reload_q[ch_sel_q][15:8];
      ADDR_COUNT_L:  data_d = count_q[ch_sel_q][7:0];
      ADDR_COUNT_H:  data_d = shadow_q;
`ifdef TIMER_SCHED_PERIODIC_EN
      ADDR_MODE:     data_d = {4'h0, mode_q};
`endif
      default:       data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '{default: '0};
      reload_q  <= '{default: '0};
      status_q  <= '0;
      running_q <= '0;
      irq_en_q  <= '0;
      ch_sel_q  <= '0;
      shadow_q  <= '0;
      data_o    <= '0;
      irq_o     <= 1'b0;
`ifdef TIMER_SCHED_PERIODIC_EN
      mode_q    <= '0;
`endif
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      status_q  <= status_d;
      running_q <= running_d;
      irq_en_q  <= irq_en_d;
      ch_sel_q  <= ch_sel_d;
      shadow_q  <= shadow_d;
      data_o    <= data_d;
      irq_o     <= |(status_q & irq_en_q);
`ifdef TIMER_SCHED_PERIODIC_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule
